// File: rtl/t04_mul_controller_if.sv
// Bundle of requester and shared-multiplier signals for t04_mul_controller.
// The controller connects through the slave modport; the environment uses master.
interface t04_mul_controller_if;
  logic        req0;
  logic        req1;
  logic [31:0] a0;
  logic [31:0] b0;
  logic [31:0] a1;
  logic [31:0] b1;
  logic        done0;
  logic        done1;
  logic [31:0] result;
  logic        busy;
  logic        mul_start;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [31:0] mul_product;
  logic        mul_ack;

  modport slave (
    input  req0, req1, a0, b0, a1, b1, mul_product, mul_ack,
    output done0, done1, result, busy, mul_start, mul_a, mul_b
  );

  modport master (
    output req0, req1, a0, b0, a1, b1, mul_product, mul_ack,
    input  done0, done1, result, busy, mul_start, mul_a, mul_b
  );
endinterface

// File: rtl/t04_mul_controller.sv
// Two-requester 32x32 (low 32 bits) multiply controller that builds each product
// from up to three passes through a shared 16x16 shift-add multiplier.
module t04_mul_controller (
  input  logic                       clk,
  input  logic                       rst,
  t04_mul_controller_if.slave        bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  pass_q, pass_d;
  logic        grant_q, grant_d;
  logic        last_q, last_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] result_q, result_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;

  logic        pick;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [31:0] addend;
  logic [31:0] sum;
  logic        has_next;
  logic [1:0]  next_pass;

  // last_q holds the most recent grant; it resets to 1 so requester 0 wins the first tie.
  assign pick = (bus.req0 & bus.req1) ? ~last_q : bus.req1;

  always_comb begin
    op_a = 16'h0000;
    op_b = 16'h0000;
    case (pass_q)
      2'd0: begin
        op_a = a_q[15:0];
        op_b = b_q[15:0];
      end
      2'd1: begin
        op_a = a_q[15:0];
        op_b = b_q[31:16];
      end
      2'd2: begin
        op_a = a_q[31:16];
        op_b = b_q[15:0];
      end
      default: begin
        op_a = 16'h0000;
        op_b = 16'h0000;
      end
    endcase
  end

  // Cross terms land 16 bits up; anything above bit 31 is discarded.
  assign addend = (pass_q == 2'd0) ? bus.mul_product
                                   : {bus.mul_product[15:0], 16'h0000};
  assign sum    = acc_q + addend;

  always_comb begin
    has_next  = 1'b0;
    next_pass = 2'd0;
    case (pass_q)
      2'd0: begin
        if (b_q[31:16] != 16'h0000) begin
          has_next  = 1'b1;
          next_pass = 2'd1;
        end else if (a_q[31:16] != 16'h0000) begin
          has_next  = 1'b1;
          next_pass = 2'd2;
        end
      end
      2'd1: begin
        if (a_q[31:16] != 16'h0000) begin
          has_next  = 1'b1;
          next_pass = 2'd2;
        end
      end
      default: begin
        has_next  = 1'b0;
        next_pass = 2'd0;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pass_d   = pass_q;
    grant_d  = grant_q;
    last_d   = last_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req0 | bus.req1) begin
          grant_d = pick;
          last_d  = pick;
          a_d     = pick ? bus.a1 : bus.a0;
          b_d     = pick ? bus.b1 : bus.b0;
          acc_d   = 32'h0000_0000;
          pass_d  = 2'd0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.mul_ack) begin
          acc_d = sum;
          if (has_next) begin
            pass_d  = next_pass;
            state_d = S_ISSUE;
          end else begin
            result_d = sum;
            done0_d  = ~grant_q;
            done1_d  = grant_q;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pass_q   <= 2'd0;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      a_q      <= 32'h0000_0000;
      b_q      <= 32'h0000_0000;
      acc_q    <= 32'h0000_0000;
      result_q <= 32'h0000_0000;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pass_q   <= pass_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
    end
  end

  // Operands are only presented while a pass is in flight, so they read 0 when idle.
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.mul_start = (state_q == S_ISSUE);
  assign bus.mul_a     = ((state_q == S_ISSUE) || (state_q == S_WAIT)) ? {16'h0000, op_a} : 32'h0000_0000;
  assign bus.mul_b     = ((state_q == S_ISSUE) || (state_q == S_WAIT)) ? {16'h0000, op_b} : 32'h0000_0000;
  assign bus.done0     = done0_q;
  assign bus.done1     = done1_q;
  assign bus.result    = result_q;

endmodule

// File: tb/tb_t04_mul_controller.sv
// Directed bench for t04_mul_controller with a behavioural shift-add multiplier and a
// per-cycle reference model of the controller's observable outputs.
module tb_t04_mul_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   nVectors = 0;
  int   nMiscompares = 0;

  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  t04_mul_controller_if bus ();

  t04_mul_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int bitLen(input logic [15:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 16; i++) if (v[i]) n = i + 1;
    return n;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Shared multiplier: acks bitlen(mul_b) cycles into WAIT; product is junk unless acked.
  int          mulCnt = 0;
  logic [31:0] mulHold = 32'h0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mul_ack     <= 1'b0;
      bus.mul_product <= JUNK;
      mulCnt          <= 0;
    end else if (bus.mul_start) begin
      mulHold <= 32'(bus.mul_a[15:0]) * 32'(bus.mul_b[15:0]);
      mulCnt  <= bitLen(bus.mul_b[15:0]);
      if (bitLen(bus.mul_b[15:0]) == 0) begin
        bus.mul_ack     <= 1'b1;
        bus.mul_product <= 32'(bus.mul_a[15:0]) * 32'(bus.mul_b[15:0]);
      end else begin
        bus.mul_ack     <= 1'b0;
        bus.mul_product <= JUNK;
      end
    end else if (mulCnt == 1) begin
      bus.mul_ack     <= 1'b1;
      bus.mul_product <= mulHold;
      mulCnt          <= 0;
    end else begin
      bus.mul_ack     <= 1'b0;
      bus.mul_product <= JUNK;
      if (mulCnt > 1) mulCnt <= mulCnt - 1;
    end
  end

  // Reference model: on grant, derive the product and the full pass schedule from the
  // arithmetic rules, then check every output on every falling edge.
  initial begin : compareProc
    bit          mActive, mWho, mLast, who;
    bit          eDone0, eDone1, eBusy, eStart, chkOps;
    int          mDone, mN, t, stop;
    int          mIssue[3];
    logic [15:0] mA[3];
    logic [15:0] mB[3];
    logic [31:0] mPend, mResult, eMa, eMb, opA, opB;
    logic [63:0] full;
    mActive = 1'b0;
    mLast   = 1'b1;
    mWho    = 1'b0;
    mResult = 32'h0;
    mPend   = 32'h0;
    mDone   = 0;
    mN      = 0;
    forever begin
      @(negedge clk);
      eDone0 = 1'b0;
      eDone1 = 1'b0;
      eBusy  = 1'b0;
      eStart = 1'b0;
      chkOps = 1'b0;
      eMa    = 32'h0;
      eMb    = 32'h0;
      if (rst) begin
        mActive = 1'b0;
        mResult = 32'h0;
        mLast   = 1'b1;
        chkOps  = 1'b1;
      end else if (mActive) begin
        eBusy = 1'b1;
        for (int i = 0; i < mN; i++) begin
          stop = (i + 1 < mN) ? mIssue[i+1] : mDone;
          if (cyc == mIssue[i]) eStart = 1'b1;
          if (cyc >= mIssue[i] && cyc < stop) begin
            chkOps = 1'b1;
            eMa    = {16'h0000, mA[i]};
            eMb    = {16'h0000, mB[i]};
          end
        end
        if (cyc == mDone) begin
          mResult = mPend;
          if (mWho) eDone1 = 1'b1;
          else      eDone0 = 1'b1;
        end
      end
      checkOutput("busy", bus.busy, eBusy);
      checkOutput("done0", bus.done0, eDone0);
      checkOutput("done1", bus.done1, eDone1);
      checkOutput("result", bus.result, mResult);
      checkOutput("mul_start", bus.mul_start, eStart);
      if (chkOps) begin
        checkOutput("mul_a", bus.mul_a, eMa);
        checkOutput("mul_b", bus.mul_b, eMb);
      end
      if (!rst) begin
        if (mActive && cyc == mDone) begin
          mActive = 1'b0;
        end else if (!mActive && (bus.req0 || bus.req1)) begin
          who   = (bus.req0 && bus.req1) ? ~mLast : bus.req1;
          mLast = who;
          mWho  = who;
          opA   = who ? bus.a1 : bus.a0;
          opB   = who ? bus.b1 : bus.b0;
          full  = 64'(opA) * 64'(opB);
          mPend = full[31:0];
          t     = cyc + 1;
          mN    = 0;
          mIssue[mN] = t; mA[mN] = opA[15:0]; mB[mN] = opB[15:0];
          t = t + 2 + bitLen(opB[15:0]); mN++;
          if (opB[31:16] != 16'h0) begin
            mIssue[mN] = t; mA[mN] = opA[15:0]; mB[mN] = opB[31:16];
            t = t + 2 + bitLen(opB[31:16]); mN++;
          end
          if (opA[31:16] != 16'h0) begin
            mIssue[mN] = t; mA[mN] = opA[31:16]; mB[mN] = opB[15:0];
            t = t + 2 + bitLen(opB[15:0]); mN++;
          end
          mDone   = t;
          mActive = 1'b1;
        end
      end
    end
  end

  task automatic applyStimulus(input bit who, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    if (who) begin
      bus.a1 = a; bus.b1 = b; bus.req1 = 1'b1;
    end else begin
      bus.a0 = a; bus.b0 = b; bus.req0 = 1'b1;
    end
  endtask

  task automatic waitDone(input int maxCycles, output int dcyc, output bit seen);
    seen = 1'b0;
    dcyc = -1;
    for (int i = 0; i < maxCycles && !seen; i++) begin
      @(negedge clk);
      if (bus.done0 || bus.done1) begin
        seen = 1'b1;
        dcyc = cyc;
      end
    end
  endtask

  task automatic noteTimeout(input string name);
    nVectors++;
    nMiscompares++;
    $display("[TB] FAIL %s timeout: no done pulse within 200 cycles", name);
  endtask

  task automatic runOne(input bit who, input logic [31:0] a, input logic [31:0] b,
                        input int expLat, input logic [31:0] expRes, input string name);
    int c0, dcyc;
    bit seen;
    applyStimulus(who, a, b);
    c0 = cyc;
    waitDone(200, dcyc, seen);
    if (!seen) begin
      noteTimeout(name);
    end else begin
      checkOutput({name, " done line"}, who ? bus.done1 : bus.done0, 32'd1);
      checkOutput({name, " latency"}, dcyc - c0, expLat);
      checkOutput({name, " result"}, bus.result, expRes);
    end
    @(posedge clk);
    #1;
    if (who) bus.req1 = 1'b0;
    else     bus.req0 = 1'b0;
  endtask

  task automatic runBoth(input logic [31:0] a0, input logic [31:0] b0, input logic [31:0] res0,
                         input logic [31:0] a1, input logic [31:0] b1, input logic [31:0] res1,
                         input string name);
    int dcyc;
    bit seen;
    @(posedge clk);
    #1;
    bus.a0 = a0; bus.b0 = b0; bus.a1 = a1; bus.b1 = b1;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    waitDone(200, dcyc, seen);
    if (!seen) noteTimeout({name, " first"});
    else begin
      checkOutput({name, " first is req0"}, bus.done0, 32'd1);
      checkOutput({name, " first result"}, bus.result, res0);
    end
    @(posedge clk);
    #1;
    bus.req0 = 1'b0;
    waitDone(200, dcyc, seen);
    if (!seen) noteTimeout({name, " second"});
    else begin
      checkOutput({name, " second is req1"}, bus.done1, 32'd1);
      checkOutput({name, " second result"}, bus.result, res1);
    end
    @(posedge clk);
    #1;
    bus.req1 = 1'b0;
  endtask

  initial begin
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.a0 = 32'h0; bus.b0 = 32'h0; bus.a1 = 32'h0; bus.b1 = 32'h0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", bus.busy, 32'd0);
    checkOutput("reset result", bus.result, 32'd0);
    checkOutput("reset mul_start", bus.mul_start, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] simultaneous requests after reset");
    runBoth(32'd3, 32'd5, 32'd15, 32'h100, 32'h20, 32'h2000, "rr round 1");
    runBoth(32'd9, 32'd9, 32'd81, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, "rr round 2");

    $display("[TB] single-requester directed vectors");
    runOne(1'b0, 32'd3, 32'd5, 6, 32'd15, "3x5");
    runOne(1'b1, 32'h0001_2345, 32'h0001_0003, 12, 32'h2348_69CF, "three pass");
    runOne(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 55, 32'h0000_0001, "all ones");
    runOne(1'b0, 32'h0000_1234, 32'h0, 3, 32'h0, "b zero");
    runOne(1'b1, 32'h0003_0002, 32'h0000_0005, 11, 32'h000F_000A, "skip pass1");

    $display("[TB] reset during WAIT");
    applyStimulus(1'b0, 32'h0001_2345, 32'h0001_0003);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.req0 = 1'b0;
    @(negedge clk);
    checkOutput("midreset busy", bus.busy, 32'd0);
    checkOutput("midreset done0", bus.done0, 32'd0);
    checkOutput("midreset result", bus.result, 32'd0);
    checkOutput("midreset mul_a", bus.mul_a, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (15) @(posedge clk);
    runOne(1'b0, 32'd7, 32'd6, 6, 32'd42, "after reset 7x6");

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/t04_mul_controller.md
T04_MUL_CONTROLLER -- requirements
Module: t04_mul_controller

Interface
REQ-001 SHALL have a single clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 req0, req1  input  1 each  multiply requests from requester 0 and requester 1.
REQ-005 a0, b0, a1, b1  input  32 each  operands; held stable by each requester while its req is high.
REQ-006 done0, done1  output  1 each  one-cycle completion pulse to the matching requester.
REQ-007 result  output  32  low 32 bits of a*b for the last completed transaction.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 mul_start  output  1  one-cycle start pulse to the shared 16x16 shift-add multiplier.
REQ-010 mul_a, mul_b  output  32 each  multiplier operands; only bits [15:0] are significant, [31:16] driven 0.
REQ-011 mul_product  input  32  multiplier product; valid when mul_ack is high.
REQ-012 mul_ack  input  1  multiplier done; ignored except in WAIT.

Function
REQ-013 FSM SHALL have states IDLE, ISSUE, WAIT, DONE, plus a 2-bit pass counter (0..2).
REQ-014 IDLE: if any req is high, the FSM SHALL grant one requester, latch its a/b, clear the accumulator, select the first pass, and go to ISSUE; otherwise it stays in IDLE.
REQ-015 Arbitration SHALL be round-robin. On a tie, grant the requester not granted last; after reset the tie-break favours requester 0.
REQ-016 Pass 0 SHALL use mul_a=a[15:0], mul_b=b[15:0], adding product to the accumulator.
REQ-017 Pass 1 SHALL use mul_a=a[15:0], mul_b=b[31:16], adding (product<<16) mod 2^32.
REQ-018 Pass 2 SHALL use mul_a=a[31:16], mul_b=b[15:0], adding (product<<16) mod 2^32.
REQ-019 Skipping: pass 1 SHALL be skipped when b[31:16]==0, and pass 2 SHALL be skipped when a[31:16]==0. Pass 0 always executes.
REQ-020 ISSUE SHALL last exactly one cycle, with mul_start=1 and mul_a/mul_b valid, then go to WAIT.
REQ-021 WAIT SHALL hold mul_a/mul_b stable with mul_start=0. In the first WAIT cycle with mul_ack=1 it SHALL accumulate mul_product, then go to ISSUE of the next executed pass, or to DONE if none remain.
REQ-022 DONE SHALL last one cycle:
- result and the granted done pulse are registered on entry, so done and result are valid together;
- the FSM then returns to IDLE;
- req is not sampled in DONE.
REQ-023 A requester SHALL drop req by the cycle after its done pulse. A req still high in IDLE is treated as a new transaction.
REQ-024 result SHALL hold its value until the next DONE. done0 and done1 SHALL never be high together.
REQ-025 Latency: done SHALL assert at cycle c0+1+Σ(2+bitlen(m_i)) over executed passes.
- c0 is the IDLE cycle in which req is sampled.
- m_i is the 16-bit mul_b value of pass i; bitlen(0)=0.
REQ-026 Arithmetic SHALL be unsigned and modulo 2^32, with no overflow indication.

Reset
REQ-027 While rst is high, all of the following SHALL be 0: done0, done1, result, busy, mul_start, mul_a, mul_b. The accumulator and latched operands SHALL be cleared, the state SHALL be IDLE, and the round-robin pointer SHALL favour requester 0.
REQ-028 Reset mid-transaction SHALL abort it with no done pulse. The first request after reset SHALL be served from IDLE normally.

Verification
REQ-029 req0, a0=3, b0=5 -> pass 0 only; mul_start at c0+1; done0 at c0+6; result=15.
REQ-030 req1, a1=0x00012345, b1=0x00010003 -> three passes; result=0x234869CF; done1 at c0+1+(2+2)+(2+1)+(2+2)=c0+12.
REQ-031 req0, a0=0xFFFFFFFF, b0=0xFFFFFFFF -> result=0x00000001 (mod 2^32).
REQ-032 req0, b0=0 -> pass 0 only with mul_b=0; done0 at c0+3; result=0.
REQ-033 req0 and req1 high together after reset -> requester 0 is served first (done0), then requester 1 (done1). Raising both again -> requester 0 first again.
REQ-034 rst pulsed during WAIT of a 3-pass job -> all outputs 0 and busy=0, with no done. A following req0 (a0=7, b0=6) -> result=42.
